// File: rtl/d_latch_pkg.sv
// Shared definitions for the d_latch_bank_pls storage bank: mode encodings,
// per-channel FSM states and the lockout-counter sizing helper.
package d_latch_pkg;

  localparam logic [1:0] MODE_TRANSP = 2'b00;
  localparam logic [1:0] MODE_EDGE   = 2'b01;
  localparam logic [1:0] MODE_TIMED  = 2'b10;
  localparam logic [1:0] MODE_FREEZE = 2'b11;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_LOCK = 1'b1;

  // A lockout of one cycle still needs a one-bit counter.
  function automatic int cnt_width(input int hold);
    return (hold > 1) ? $clog2(hold) : 1;
  endfunction

endpackage

// File: rtl/d_latch_cell.sv
// One storage channel: data register, enable edge detect, timed-hold lockout
// FSM with its down-counter, and a saturating age counter.
module d_latch_cell
  import d_latch_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int HOLD_CYCLES = 4,
  parameter int AGE_W       = 8
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic [WIDTH-1:0] d_in,
  input  logic             en_in,
  input  logic             clr_in,
  input  logic [1:0]       mode_in,
  output logic [WIDTH-1:0] q_out,
  output logic             valid_out,
  output logic             busy_out,
  output logic [AGE_W-1:0] age_out
);

  localparam int                CNT_W    = cnt_width(HOLD_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [AGE_W-1:0]  AGE_MAX  = '1;

  logic [WIDTH-1:0] r_q;
  logic             r_valid;
  logic [AGE_W-1:0] r_age;
  logic [0:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_en_d;

  logic             w_rise;
  logic             w_capture;
  logic [0:0]       w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;

  assign w_rise = en_in & ~r_en_d;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves it unassigned and no latch is inferred.
    w_capture   = 1'b0;
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (mode_in)
      MODE_TRANSP: begin
        w_capture   = en_in;
        w_state_nxt = ST_IDLE;
      end
      MODE_EDGE: begin
        w_capture   = w_rise;
        w_state_nxt = ST_IDLE;
      end
      MODE_TIMED: begin
        if (r_state == ST_IDLE) begin
          if (en_in) begin
            w_capture   = 1'b1;
            w_state_nxt = ST_LOCK;
            w_cnt_nxt   = CNT_LOAD;
          end
        end else if (r_cnt == '0) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      default: ; // FREEZE: lockout state and counter pause, nothing captures
    endcase
    if (clr_in) begin
      w_capture   = 1'b0;
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_q     <= '0;
      r_valid <= 1'b0;
      r_age   <= '0;
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_en_d  <= 1'b0;
    end else begin
      r_en_d  <= en_in;
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (clr_in) begin
        r_q     <= '0;
        r_valid <= 1'b0;
        r_age   <= '0;
      end else if (w_capture) begin
        r_q     <= d_in;
        r_valid <= 1'b1;
        r_age   <= '0;
      end else if (r_valid && (r_age != AGE_MAX)) begin
        r_age <= r_age + 1'b1;
      end
    end
  end

  assign q_out     = r_q;
  assign valid_out = r_valid;
  assign busy_out  = (r_state == ST_LOCK);
  assign age_out   = r_age;

endmodule

// File: rtl/d_latch_bank_pls.sv
// Bank of CHANNELS independent storage cells under one global capture mode;
// packs per-channel data, status and age onto flat buses.
module d_latch_bank_pls
  import d_latch_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int CHANNELS    = 4,
  parameter int HOLD_CYCLES = 4,
  parameter int AGE_W       = 8
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic [CHANNELS*WIDTH-1:0] d_in,
  input  logic [CHANNELS-1:0]       en_in,
  input  logic [CHANNELS-1:0]       clr_in,
  input  logic [1:0]                mode_in,
  output logic [CHANNELS*WIDTH-1:0] q_out,
  output logic [CHANNELS-1:0]       valid_out,
  output logic [CHANNELS-1:0]       busy_out,
  output logic [CHANNELS*AGE_W-1:0] age_out
);

  for (genvar g = 0; g < CHANNELS; g++) begin : g_cell
    d_latch_cell #(
      .WIDTH      (WIDTH),
      .HOLD_CYCLES(HOLD_CYCLES),
      .AGE_W      (AGE_W)
    ) u_cell (
      .clk_in   (clk_in),
      .rst_in   (rst_in),
      .d_in     (d_in[g*WIDTH +: WIDTH]),
      .en_in    (en_in[g]),
      .clr_in   (clr_in[g]),
      .mode_in  (mode_in),
      .q_out    (q_out[g*WIDTH +: WIDTH]),
      .valid_out(valid_out[g]),
      .busy_out (busy_out[g]),
      .age_out  (age_out[g*AGE_W +: AGE_W])
    );
  end

endmodule

// File: tb/tb_d_latch_bank_pls.sv
// Directed scoreboard bench for d_latch_bank_pls: stimulus pushes hand-computed
// expectations tagged with the edge they follow; a negedge monitor checks them.
module tb_d_latch_bank_pls;

  localparam int WIDTH = 8, CHANNELS = 4, HOLD_CYCLES = 4, AGE_W = 8;
  localparam int F_Q = 0, F_VALID = 1, F_BUSY = 2, F_AGE = 3;

  logic                      clk_in = 1'b0;
  logic                      rst_in;
  logic [CHANNELS*WIDTH-1:0] d_in;
  logic [CHANNELS-1:0]       en_in;
  logic [CHANNELS-1:0]       clr_in;
  logic [1:0]                mode_in;
  logic [CHANNELS*WIDTH-1:0] q_out;
  logic [CHANNELS-1:0]       valid_out;
  logic [CHANNELS-1:0]       busy_out;
  logic [CHANNELS*AGE_W-1:0] age_out;

  d_latch_bank_pls #(
    .WIDTH(WIDTH), .CHANNELS(CHANNELS), .HOLD_CYCLES(HOLD_CYCLES), .AGE_W(AGE_W)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in), .d_in(d_in), .en_in(en_in), .clr_in(clr_in),
    .mode_in(mode_in), .q_out(q_out), .valid_out(valid_out), .busy_out(busy_out),
    .age_out(age_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    int    cyc;
    int    ch;
    int    fld;
    int    val;
    string name;
  } exp_t;

  exp_t sb[$];
  int   edge_cnt = 0;
  int   n_checks = 0;
  int   n_fail   = 0;

  always @(posedge clk_in) edge_cnt <= edge_cnt + 1;

  task automatic check(input string name, input int ch, input int act, input int exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s ch%0d: got 0x%0h, expected 0x%0h (t=%0t)", name, ch, act, exp_v, $time);
    end
  endtask

  function automatic int actual(input int ch, input int fld);
    case (fld)
      F_Q:     return int'(q_out[ch*WIDTH +: WIDTH]);
      F_VALID: return int'(valid_out[ch]);
      F_BUSY:  return int'(busy_out[ch]);
      default: return int'(age_out[ch*AGE_W +: AGE_W]);
    endcase
  endfunction

  // Monitor: outputs are stable at the falling edge; check everything due by now.
  always @(negedge clk_in) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].cyc <= edge_cnt) begin
      e = sb.pop_front();
      check(e.name, e.ch, actual(e.ch, e.fld), e.val);
    end
  end

  // Expectation for the state visible after the next rising edge.
  task automatic push_exp(input string name, input int ch, input int fld, input int val);
    exp_t e;
    e.cyc  = edge_cnt + 1;
    e.ch   = ch;
    e.fld  = fld;
    e.val  = val;
    e.name = name;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(negedge clk_in);
    #1;
  endtask

  task automatic set_d(input int ch, input logic [WIDTH-1:0] v);
    d_in[ch*WIDTH +: WIDTH] = v;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout, expected test completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_in  = 1'b1;
    d_in    = '0;
    en_in   = '0;
    clr_in  = '0;
    mode_in = 2'b00;
    tick();
    check("reset_q", -1, int'(q_out), 0);
    check("reset_valid", -1, int'(valid_out), 0);
    tick();
    rst_in = 1'b0;

    // Reset mid-operation: TIMED capture on ch0, async reset two cycles later.
    tick();
    mode_in = 2'b10; en_in = 4'b0001; set_d(0, 8'hA5);
    push_exp("rst_cap_q", 0, F_Q, 'hA5);
    push_exp("rst_cap_busy", 0, F_BUSY, 1);
    tick();
    en_in = '0;
    push_exp("rst_age1", 0, F_AGE, 1);
    tick();
    push_exp("rst_age2", 0, F_AGE, 2);
    push_exp("rst_busy2", 0, F_BUSY, 1);
    tick();
    #2 rst_in = 1'b1;
    #1;
    check("async_q", -1, int'(q_out), 0);
    check("async_valid", -1, int'(valid_out), 0);
    check("async_busy", -1, int'(busy_out), 0);
    check("async_age", -1, int'(age_out), 0);
    tick();
    rst_in = 1'b0;
    tick();
    en_in = 4'b0001; set_d(0, 8'h3C);
    push_exp("recap_q", 0, F_Q, 'h3C);
    push_exp("recap_valid", 0, F_VALID, 1);
    push_exp("recap_busy", 0, F_BUSY, 1);

    // TRANSP on ch0 (also forces the pending lockout back to idle).
    tick();
    mode_in = 2'b00; set_d(0, 8'h11);
    push_exp("transp_q11", 0, F_Q, 'h11);
    push_exp("transp_busy", 0, F_BUSY, 0);
    tick();
    set_d(0, 8'h22);
    push_exp("transp_q22", 0, F_Q, 'h22);
    tick();
    set_d(0, 8'h33);
    push_exp("transp_q33", 0, F_Q, 'h33);
    push_exp("transp_age0", 0, F_AGE, 0);
    tick();
    en_in = '0; set_d(0, 8'h44);
    for (int i = 1; i <= 3; i++) begin
      push_exp("transp_hold_q", 0, F_Q, 'h33);
      push_exp("transp_age", 0, F_AGE, i);
      if (i < 3) tick();
    end

    // EDGE on ch1: a held-high enable captures once.
    tick();
    mode_in = 2'b01; en_in = 4'b0010;
    for (int i = 1; i <= 5; i++) begin
      set_d(1, 8'(i));
      push_exp("edge_q", 1, F_Q, 'h01);
      push_exp("edge_age", 1, F_AGE, i - 1);
      tick();
    end
    en_in = '0;
    push_exp("edge_low_q", 1, F_Q, 'h01);
    tick();
    en_in = 4'b0010; set_d(1, 8'h77);
    push_exp("edge_recap_q", 1, F_Q, 'h77);
    push_exp("edge_recap_age", 1, F_AGE, 0);

    // TIMED on ch2: captures at edges 0, 5, 10.
    for (int j = 0; j <= 10; j++) begin
      tick();
      mode_in = 2'b10; en_in = 4'b0100; set_d(2, 8'(8'h10 + j));
      push_exp("timed_q", 2, F_Q, 'h10 + j - (j % 5));
      push_exp("timed_busy", 2, F_BUSY, ((j % 5) < 4) ? 1 : 0);
    end

    // FREEZE mid-lockout on ch3.
    tick();
    en_in = 4'b1000; set_d(3, 8'hC3);
    push_exp("frz_cap_q", 3, F_Q, 'hC3);
    push_exp("frz_cap_busy", 3, F_BUSY, 1);
    tick();
    en_in = '0;
    push_exp("frz_busy1", 3, F_BUSY, 1);
    push_exp("frz_age1", 3, F_AGE, 1);
    for (int i = 2; i <= 4; i++) begin
      tick();
      mode_in = 2'b11; en_in = 4'b1000; set_d(3, 8'h55);
      push_exp("frz_q", 3, F_Q, 'hC3);
      push_exp("frz_valid", 3, F_VALID, 1);
      push_exp("frz_busy", 3, F_BUSY, 1);
      push_exp("frz_age", 3, F_AGE, i);
    end
    for (int i = 5; i <= 7; i++) begin
      tick();
      mode_in = 2'b10; en_in = '0;
      push_exp("unfrz_busy", 3, F_BUSY, (i < 7) ? 1 : 0);
      push_exp("unfrz_q", 3, F_Q, 'hC3);
      push_exp("unfrz_age", 3, F_AGE, i);
    end

    // Clear beats enable in TRANSP.
    tick();
    mode_in = 2'b00; en_in = 4'b1000; clr_in = 4'b1000; set_d(3, 8'h99);
    push_exp("clr_q", 3, F_Q, 0);
    push_exp("clr_valid", 3, F_VALID, 0);
    push_exp("clr_age", 3, F_AGE, 0);
    tick();
    en_in = '0; clr_in = '0;
    push_exp("clr_hold_valid", 3, F_VALID, 0);
    tick();
    push_exp("clr_age_stays0", 3, F_AGE, 0);

    // Age saturation on ch1.
    tick();
    en_in = 4'b0010; set_d(1, 8'h5A);
    push_exp("sat_cap_q", 1, F_Q, 'h5A);
    push_exp("sat_cap_age", 1, F_AGE, 0);
    tick();
    en_in = '0;
    for (int i = 1; i <= 300; i++) begin
      if (i == 1 || i == 254 || i == 255 || i == 256 || i == 300)
        push_exp("sat_age", 1, F_AGE, (i > 255) ? 255 : i);
      if (i < 300) tick();
    end

    for (int k = 0; k < 5 && sb.size() > 0; k++) tick();
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check({"unchecked_", e.name}, e.ch, -1, e.val);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/d_latch_bank_pls.md
Name: d_latch_bank_pls

Overview:
- Parametrised, fully synchronous successor to the single-bit enable latch.
- CHANNELS independent WIDTH-bit storage cells share one clock. A global mode selects how each cell captures data:
  - level-transparent
  - enable-edge capture
  - timed-hold with post-capture lockout
  - global freeze
- Each channel reports valid, busy (lockout active) and a saturating age counter, so downstream logic can tell whether held data is stale.
- Sits between asynchronous-ish sample sources and consumers that need held values.

Parameters:
- WIDTH, 8, data bits per channel.
- CHANNELS, 4, number of independent cells (>=1).
- HOLD_CYCLES, 4, lockout length in cycles after a timed-hold capture (>=1).
- AGE_W, 8, width of the per-channel age counter. Saturates at 2^AGE_W-1.

Ports:
- clk_in, in, 1, single clock. All state updates on the rising edge.
- rst_in, in, 1, asynchronous, active-high reset.
- d_in, in, CHANNELS*WIDTH, packed data. Channel i occupies bits [i*WIDTH +: WIDTH].
- en_in, in, CHANNELS, per-channel enable.
- clr_in, in, CHANNELS, per-channel synchronous clear.
- mode_in, in, 2, global mode: 00 TRANSP, 01 EDGE, 10 TIMED, 11 FREEZE.
- q_out, out, CHANNELS*WIDTH, held data, packed like d_in.
- valid_out, out, CHANNELS, channel holds data captured since last reset/clear.
- busy_out, out, CHANNELS, channel in lockout (TIMED mode). Enables are ignored while set.
- age_out, out, CHANNELS*AGE_W, cycles since last capture, saturating.

Behaviour:
- Reset (rst_in=1, asynchronous):
  - q_out=0, valid_out=0, busy_out=0, age_out=0.
  - All channel FSMs go to IDLE. Edge-detect registers (en_d) are cleared to 0.
  - Reset asserted mid-lockout aborts the lockout immediately.
- Latency: one cycle. A capture at edge k makes q_out=d_in (as sampled at edge k) visible after edge k. Outputs are registered, with no combinational path from input to output.
- en_d[i] registers en_in[i] every cycle in all modes, including FREEZE. Edge detect is en_in[i] & ~en_d[i].
- Per-channel priority, highest first: clr_in > mode rules.
- clr_in[i]=1: q=0, valid=0, age=0, state=IDLE, busy=0. This holds in every mode, including FREEZE.
- TRANSP (00):
  - en_in[i]=1 -> capture; otherwise hold.
  - State is forced to IDLE and busy to 0.
- EDGE (01):
  - Capture only on the cycle where an en rising edge is detected.
  - A continuously high en captures once.
  - State is forced to IDLE.
- TIMED (10), per-channel FSM:
  - IDLE: if en_in[i]=1 -> capture, cnt=HOLD_CYCLES-1, go to LOCK, busy=1.
  - LOCK: en ignored. If cnt==0 -> IDLE, busy=0; else cnt-1.
  - busy is therefore high for exactly HOLD_CYCLES cycles. The earliest re-capture is HOLD_CYCLES+1 cycles after the previous one.
- FREEZE (11):
  - No captures. q and valid are held.
  - The LOCK counter and state pause.
  - Age continues counting.
- Leaving TIMED for TRANSP/EDGE: the next edge forces IDLE, busy=0, and applies the new mode's capture rule on that same edge.
- Entering EDGE with en already high: no capture unless en_d was 0.
- Capture: q=d slice, valid=1, age=0.
- Age:
  - When valid=1 and no capture, age increments and saturates at 2^AGE_W-1.
  - When valid=0, age stays 0.
- Counter width: clog2(HOLD_CYCLES) with a minimum of 1 bit. HOLD_CYCLES=1 gives exactly one busy cycle.
- Channels are fully independent. Simultaneous capture on all channels is legal.

Decomposition:
- Shared package d_latch_pkg holds:
  - mode localparams MODE_TRANSP/EDGE/TIMED/FREEZE
  - FSM state encoding ST_IDLE/ST_LOCK
- Natural sub-module: d_latch_cell. This is one channel: data register, edge detect, lockout FSM/counter and age counter.
- The top instantiates CHANNELS cells in a generate loop and packs/unpacks the buses.

Test Plan (WIDTH=8, CHANNELS=4, HOLD_CYCLES=4, AGE_W=8):
- Reset mid-operation:
  - Stimulus: TIMED, ch0 captures 0xA5; assert rst_in asynchronously two cycles later, between clock edges.
  - Required response: q_out, valid, busy and age go to 0 immediately, without waiting for a clock edge. After release, ch0 re-captures on the first enable.
- TRANSP:
  - Stimulus: en0=1 while d0 steps 0x11, 0x22, 0x33, then en0=0 with d0=0x44.
  - Required response: q0 follows with 1-cycle lag and holds 0x33. Age counts 1, 2, 3 while held.
- EDGE:
  - Stimulus: en1 held high 5 cycles, d1 changing 0x01..0x05.
  - Required response: q1=0x01 only. Dropping en1 and raising it again with d1=0x77 gives q1=0x77.
- TIMED:
  - Stimulus: en2 held high, d2 incrementing from 0x10 each cycle.
  - Required response: captures at edges 0, 5 and 10 (q2=0x10, 0x15, 0x1A). busy2 is high for 4 cycles after each capture.
- FREEZE mid-lockout:
  - Stimulus: TIMED capture, then after 2 busy cycles switch to 11 for 3 cycles, then back to 10.
  - Required response: busy stays high 2 more cycles after the return. q is unchanged during freeze. Age keeps incrementing.
- Clear priority and age saturation:
  - Stimulus: clr3=1 with en3=1 in TRANSP.
  - Required response: q3=0, valid3=0. Separately, a channel held 300 cycles reads age=255.
